// File: rtl/twiddle_gen_if.sv
// twiddle_gen_if: start/stage command plus valid/ready twiddle stream (master = twiddle_gen, slave = controller/consumer); optional inverse under TWIDDLE_INVERSE_EN
interface twiddle_gen_if #(
  parameter int LOG2N = 3,
  parameter int WIDTH = 12
);
  localparam int SW = $clog2(LOG2N);
  logic start;
  logic [SW-1:0] stage;
  logic out_ready;
  logic out_valid;
  logic signed [WIDTH-1:0] tw_rea;
  logic signed [WIDTH-1:0] tw_img;
  logic [LOG2N-2:0] tw_exp;
  logic out_last;
  logic busy;
  logic done;
`ifdef TWIDDLE_INVERSE_EN
  logic inverse;
  modport master (input start, stage, inverse, out_ready,
                  output out_valid, tw_rea, tw_img, tw_exp, out_last, busy, done);
  modport slave (output start, stage, inverse, out_ready,
                 input out_valid, tw_rea, tw_img, tw_exp, out_last, busy, done);
`else
  modport master (input start, stage, out_ready,
                  output out_valid, tw_rea, tw_img, tw_exp, out_last, busy, done);
  modport slave (output start, stage, out_ready,
                 input out_valid, tw_rea, tw_img, tw_exp, out_last, busy, done);
`endif
endinterface

// File: rtl/twiddle_gen.sv
// twiddle_gen: streams the N/2 radix-2 twiddles of one FFT stage from a folded quarter-wave cosine table; ports clk, rst (async high), bus (twiddle_gen_if.master); TWIDDLE_INVERSE_EN adds conjugate (IFFT) mode
module twiddle_gen #(
  parameter int LOG2N = 3,
  parameter int WIDTH = 12,
  parameter int AMP = 127
) (
  input logic clk,
  input logic rst,
  twiddle_gen_if.master bus
);
  localparam int EW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam int Q4I = 1 << (LOG2N - 2);
  localparam logic [EW-1:0] Q4 = EW'(Q4I);
  localparam real PI = 3.14159265358979323846;
  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;
  state_t state;
  logic [EW-1:0] cnt, jv, ev, ci, si;
  logic [SW-1:0] stg;
  logic le, fire, inv;
  logic signed [WIDTH-1:0] q [Q4I+1];
  logic signed [WIDTH-1:0] cos_v, sin_v, img_v;
  for (genvar k = 0; k <= Q4I; k++) begin : g_q
    localparam real C = AMP * $cos(2.0 * PI * k / (1 << LOG2N));
    localparam int QI = C >= 0.0 ? $rtoi(C + 0.5) : -$rtoi(0.5 - C);
    assign q[k] = WIDTH'(QI);
  end
`ifdef TWIDDLE_INVERSE_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) inv <= 1'b0;
    else if (state == IDLE && bus.start) inv <= bus.inverse;
`else
  assign inv = 1'b0;
`endif
  // cnt = g*span + j, so j is its low s bits and e = j*stride is a shift
  always_comb begin
    jv = cnt & EW'((1 << stg) - 1);
    ev = jv << (EW - int'(stg));
    le = ev <= Q4;
    ci = le ? ev : -ev;
    si = le ? Q4 - ev : ev - Q4;
    cos_v = le ? q[ci] : -q[ci];
    sin_v = q[si];
    img_v = inv ? sin_v : -sin_v;
    fire = !bus.out_valid || bus.out_ready;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      stg <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.tw_rea <= '0;
      bus.tw_img <= '0;
      bus.tw_exp <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start && int'(bus.stage) < LOG2N) begin
          stg <= bus.stage;
          cnt <= '0;
          bus.busy <= 1'b1;
          state <= RUN;
        end
        RUN: if (fire) begin
          bus.tw_rea <= cos_v;
          bus.tw_img <= img_v;
          bus.tw_exp <= ev;
          bus.out_last <= &cnt;
          bus.out_valid <= 1'b1;
          cnt <= cnt + 1'b1;
          state <= &cnt ? LAST : RUN;
        end
        LAST: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.out_last <= 1'b0;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_twiddle_gen.sv
// tb_twiddle_gen: randomized self-checking bench for twiddle_gen against a trig-based reference model
module tb_twiddle_gen;
  localparam int LOG2N = 3, WIDTH = 12, AMP = 127;
  localparam int N = 1 << LOG2N, H = N / 2, EW = LOG2N - 1, SW = $clog2(LOG2N);
  localparam int TW = 2 * WIDTH + EW + 1;
`ifdef TWIDDLE_INVERSE_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  twiddle_gen_if #(.LOG2N(LOG2N), .WIDTH(WIDTH)) bus ();
  twiddle_gen #(.LOG2N(LOG2N), .WIDTH(WIDTH), .AMP(AMP)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic int rnd(real x);
    return x >= 0.0 ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  // idx-th twiddle of stage s: outer group loop, inner j loop, e = j*G
  function automatic logic [TW-1:0] model(int s, int idx, bit inv);
    int span = 1 << s;
    int grp = N / (2 * span);
    int e = (idx % span) * grp;
    real a = 2.0 * 3.14159265358979 * e / N;
    int re = rnd(AMP * $cos(a));
    int im = rnd(AMP * $sin(a));
    logic [WIDTH-1:0] rv, iv;
    logic [EW-1:0] evv;
    rv = WIDTH'(re);
    iv = WIDTH'(inv ? im : -im);
    evv = EW'(e);
    return {rv, iv, evv, idx == H - 1};
  endfunction

  function automatic logic [TW-1:0] obs();
    return {bus.tw_rea, bus.tw_img, bus.tw_exp, bus.out_last};
  endfunction

  task automatic issue(int s, bit inv);
    bus.start = 1'b1;
    bus.stage = SW'(s);
`ifdef TWIDDLE_INVERSE_EN
    bus.inverse = inv;
`endif
  endtask

  // start must already be driven; mode 0 ready=1, 1 pattern 1,0,0,1, 2 random
  task automatic run_stage(int s, bit inv, int mode, int next_s, bit next_inv);
    int idx = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [TW-1:0] held = '0;
    logic [TW-1:0] exp_v;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.stage = SW'($urandom);
`ifdef TWIDDLE_INVERSE_EN
    bus.inverse = 1'($urandom);
`endif
    tests++;
    if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL accept s=%0d: busy=%b valid=%b done=%b, want 1 0 0", s, bus.busy, bus.out_valid, bus.done);
    end
    while (idx < H && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      bus.out_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 1 || cyc % 4 == 0) : 1'($urandom);
      bus.start = mode == 1 && cyc == 3;
      if (stalled) begin
        tests++;
        if (bus.out_valid !== 1'b1 || obs() !== held) begin
          fails++;
          $display("FAIL stall s=%0d: valid=%b data=%h, want 1 %h", s, bus.out_valid, obs(), held);
        end
      end
      if (mode == 0) begin
        tests++;
        if (bus.out_valid !== 1'b1) begin
          fails++;
          $display("FAIL bubble s=%0d idx=%0d: valid=%b, want 1", s, idx, bus.out_valid);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        exp_v = model(s, idx, inv);
        tests++;
        if (obs() !== exp_v) begin
          fails++;
          $display("FAIL data s=%0d idx=%0d inv=%b: got %h, want %h", s, idx, inv, obs(), exp_v);
        end
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = bus.out_valid === 1'b1;
        held = obs();
      end
    end
    bus.start = 1'b0;
    if (idx < H) begin
      tests++;
      fails++;
      $display("FAIL timeout s=%0d: %0d handshakes, want %0d", s, idx, H);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL done s=%0d: done=%b valid=%b busy=%b, want 1 0 0", s, bus.done, bus.out_valid, bus.busy);
    end
    if (next_s >= 0) issue(next_s, next_inv);
    else begin
      @(posedge clk); #1;
      tests++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        fails++;
        $display("FAIL done_pulse s=%0d: done=%b busy=%b, want 0 0", s, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({bus.out_valid, bus.out_last, bus.busy, bus.done} !== 4'b0 || bus.tw_rea !== '0 || bus.tw_img !== '0 || bus.tw_exp !== '0) begin
      fails++;
      $display("FAIL reset: valid=%b last=%b busy=%b done=%b re=%h im=%h e=%h, want all 0", bus.out_valid, bus.out_last, bus.busy, bus.done, bus.tw_rea, bus.tw_img, bus.tw_exp);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_stages();
    for (int s = 0; s < LOG2N; s++) begin
      issue(s, 1'b0);
      run_stage(s, 1'b0, 0, -1, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    bit inv = INV_EN & 1'($urandom);
    issue(2, inv);
    run_stage(2, inv, 1, -1, 1'b0);
  endtask

  task automatic test_bad_stage();
    issue(3, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      tests++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL bad_stage: busy=%b valid=%b, want 0 0", bus.busy, bus.out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    issue(2, 1'b0);
    run_stage(2, 1'b0, 0, 1, 1'b0);
    run_stage(1, 1'b0, 0, 0, INV_EN);
    run_stage(0, INV_EN, 2, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int hs = 0;
    int cyc = 0;
    issue(2, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    while (hs < 2 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.out_valid === 1'b1) hs++;
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    tests++;
    if ({bus.out_valid, bus.out_last, bus.busy, bus.done} !== 4'b0 || bus.tw_rea !== '0 || bus.tw_img !== '0 || bus.tw_exp !== '0) begin
      fails++;
      $display("FAIL reset_mid: valid=%b last=%b busy=%b done=%b re=%h im=%h e=%h, want all 0", bus.out_valid, bus.out_last, bus.busy, bus.done, bus.tw_rea, bus.tw_img, bus.tw_exp);
    end
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: done=%b busy=%b valid=%b, want 0 0 0", bus.done, bus.busy, bus.out_valid);
    end
    issue(1, 1'b0);
    run_stage(1, 1'b0, 0, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      int s = $urandom_range(LOG2N - 1);
      bit inv = INV_EN & 1'($urandom);
      issue(s, inv);
      run_stage(s, inv, $urandom_range(2), -1, 1'b0);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stage = '0;
    bus.out_ready = 1'b0;
`ifdef TWIDDLE_INVERSE_EN
    bus.inverse = 1'b0;
`endif
    test_reset();
    @(posedge clk); #1;
    test_stages();
    test_backpressure();
    test_bad_stage();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
